slow_sample_buffer: RTL and testbench
=====================================

SLOW_SAMPLE_BUFFER -- requirements
Module: slow_sample_buffer

Interface
REQ-001 SHALL have parameter N, default 12, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-003 SHALL have port slow_clk, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sample_in, input, N, synchronized sample already stable in the slow_clk domain.
REQ-006 SHALL have port enable, input, 1, capture enable.
REQ-007 SHALL have port decim, input, 8, decimation ratio; one capture every decim+1 enabled cycles.
REQ-008 SHALL have port out_data, output, N, FIFO head sample.
REQ-009 SHALL have port out_valid, output, 1, high when FIFO is non-empty.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts out_data when out_valid and out_ready are both high.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1, current FIFO occupancy.
REQ-012 SHALL have port overflow, output, 1, sticky flag set when a sample is dropped.
REQ-013 SHALL have port overflow_clr, input, 1, clears overflow.

Function
REQ-014 Decimation counter SHALL be 8 bits: when enable=1 it increments each cycle; at count==decim it wraps to 0 and a capture strobe fires in that cycle.
REQ-015 decim=0 SHALL capture sample_in on every enabled cycle; decim=255 SHALL capture once every 256 enabled cycles.
REQ-016 When enable=0, the counter SHALL reset to 0 and no capture SHALL occur.
REQ-017 A decim change mid-count SHALL take effect immediately; a count already above the new decim SHALL wrap through 255 to 0 without capturing.
REQ-018 Capture SHALL push the sample_in value present at that edge into the FIFO.
REQ-019 Pop SHALL occur when out_valid and out_ready are both high; the next entry, if any, SHALL appear on out_data on the following cycle.
REQ-020 Latency SHALL be 1 cycle: a capture into an empty FIFO drives out_valid=1 and out_data=sample on the next cycle.
REQ-021 Push with FIFO full and no pop SHALL drop the sample, leave contents unchanged, and set overflow the next cycle.
REQ-022 Simultaneous push and pop when full SHALL both succeed; level stays DEPTH and overflow is not set.
REQ-023 Simultaneous push and pop when empty SHALL be impossible (out_valid=0); the push alone SHALL proceed.
REQ-024 out_ready while empty SHALL have no effect; level never underflows.
REQ-025 level SHALL change by +1, -1 or 0 per cycle, consistent with REQ-019 to REQ-024.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 overflow_clr SHALL clear overflow; if a drop occurs in the same cycle, set SHALL win.
REQ-028 out_data SHALL be held stable while out_valid=1 and out_ready=0.

Reset
REQ-029 On reset: counter=0, pointers=0, level=0, out_valid=0, out_data=0, overflow=0; the FIFO SHALL be empty.
REQ-030 Reset asserted mid-operation SHALL discard all stored samples and any capture in that cycle; reset SHALL override every other input.
REQ-031 The first capture after reset deasserts SHALL occur on the (decim+1)th enabled cycle.

Configuration
REQ-032 Macro SLOW_SAMPLE_PEAK_EN defined: SHALL add output peak, width N, holding the maximum unsigned value pushed since reset or overflow_clr; reset value 0; updates the cycle after a push.
REQ-033 Macro SLOW_SAMPLE_PEAK_EN undefined: peak port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Reset, enable=1, decim=0, sample_in=0x123, out_ready=0 -> out_valid=1 and out_data=0x123 on cycle 2; level reaches 8 after 8 captures.
REQ-035 FIFO full, one further capture with out_ready=0 -> sample dropped, overflow=1, level=8; overflow_clr -> overflow=0 next cycle.
REQ-036 FIFO full, decim=0, out_ready=1 held -> level stays 8, overflow stays 0, out_data sequence in capture order.
REQ-037 decim=3, enable=1 for 12 cycles, out_ready=1 -> exactly 3 captures, each 4 cycles apart.
REQ-038 level=5, reset pulsed for 1 cycle -> out_valid=0, level=0, overflow=0 next cycle.
REQ-039 With SLOW_SAMPLE_PEAK_EN, push 0x100, 0xFFF, 0x010 -> peak=0xFFF; overflow_clr -> peak=0.

Source files
------------

// File: rtl/slow_sample_buffer.sv
// Decimating sample capture into a small FIFO, single slow_clk domain.
// Optional peak tracker enabled by defining SLOW_SAMPLE_PEAK_EN.
module slow_sample_buffer #(
    parameter int N     = 12,
    parameter int DEPTH = 8
) (
    input  logic                       slow_clk,
    input  logic                       reset,
    input  logic [N-1:0]               sample_in,
    input  logic                       enable,
    input  logic [7:0]                 decim,
    output logic [N-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       overflow_clr
`ifdef SLOW_SAMPLE_PEAK_EN
    ,
    output logic [N-1:0]               peak
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [7:0]    cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [N-1:0]  mem [DEPTH];

    logic cap;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign cap  = enable && (cnt == decim);
    assign full = (level == FULL);
    assign pop  = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = cap && (!full || pop);
    assign drop = cap && full && !pop;

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge slow_clk) begin
        if (!reset && push)
            mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge slow_clk) begin
        if (reset) begin
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (!enable || cap)
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;

            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);

            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase

            if (drop)
                overflow <= 1'b1;
            else if (overflow_clr)
                overflow <= 1'b0;
        end
    end

`ifdef SLOW_SAMPLE_PEAK_EN
    always_ff @(posedge slow_clk) begin
        if (reset)
            peak <= '0;
        else if (overflow_clr)
            peak <= push ? sample_in : '0;
        else if (push && (sample_in > peak))
            peak <= sample_in;
    end
`endif

endmodule

// File: tb/tb_slow_sample_buffer.sv
// Scoreboard bench for slow_sample_buffer: reference model predicts
// captures, drops and pops; queue holds expected FIFO contents.
module tb_slow_sample_buffer;

    localparam int N     = 12;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          slow_clk = 1'b0;
    logic          reset;
    logic [N-1:0]  sample_in;
    logic          enable;
    logic [7:0]    decim;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic          overflow_clr;
`ifdef SLOW_SAMPLE_PEAK_EN
    logic [N-1:0]  peak;
`endif

    slow_sample_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .slow_clk    (slow_clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .enable      (enable),
        .decim       (decim),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .level       (level),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
`ifdef SLOW_SAMPLE_PEAK_EN
        ,
        .peak        (peak)
`endif
    );

    always #5 slow_clk = ~slow_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    // Reference model state
    logic [N-1:0] sb[$];
    int           m_cnt  = 0;
    bit           m_ovf  = 0;
    logic [N-1:0] m_peak = '0;
    int           cyc    = 0;
    bit           track  = 0;
    int           rises[$];

    always @(negedge slow_clk) begin
        bit cap;
        bit drop;
        bit pushed;
        cyc++;
        check("valid", 32'(out_valid), 32'(sb.size() != 0));
        check("level", 32'(level), 32'(sb.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SLOW_SAMPLE_PEAK_EN
        check("peak", 32'(peak), 32'(m_peak));
`endif
        if (track && out_valid)
            rises.push_back(cyc);
        if (reset) begin
            sb.delete();
            m_cnt  = 0;
            m_ovf  = 0;
            m_peak = '0;
        end else begin
            cap    = enable && (m_cnt == int'(decim));
            drop   = 0;
            pushed = 0;
            if (sb.size() != 0 && out_ready)
                check("data", 32'(out_data), 32'(sb.pop_front()));
            if (cap) begin
                if (sb.size() < DEPTH) begin
                    sb.push_back(sample_in);
                    pushed = 1;
                end else begin
                    drop = 1;
                end
            end
            if (!enable || cap)
                m_cnt = 0;
            else
                m_cnt = (m_cnt + 1) % 256;
            if (drop)
                m_ovf = 1;
            else if (overflow_clr)
                m_ovf = 0;
            if (overflow_clr)
                m_peak = '0;
            if (pushed && sample_in > m_peak)
                m_peak = sample_in;
        end
    end

    task automatic tick();
        @(posedge slow_clk);
        #2;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        decim        = 8'd0;
        sample_in    = '0;
        out_ready    = 1'b0;
        overflow_clr = 1'b0;
        repeat (2) tick();
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);

        // First capture lands one cycle later
        reset     = 1'b0;
        enable    = 1'b1;
        sample_in = 12'h123;
        tick();
        check("lat_valid", 32'(out_valid), 32'h1);
        check("lat_data", 32'(out_data), 32'h123);
        for (int i = 1; i < 8; i++) begin
            sample_in = 12'(12'h120 + i);
            tick();
        end
        check("fill_level", 32'(level), 32'd8);

        // Drop on full
        sample_in = 12'h5a5;
        tick();
        check("drop_level", 32'(level), 32'd8);
        check("drop_ovf", 32'(overflow), 32'h1);
        check("hold_data", 32'(out_data), 32'h123);
        enable       = 1'b0;
        overflow_clr = 1'b1;
        tick();
        check("clr_ovf", 32'(overflow), 32'h0);

        // Set wins over clear
        enable = 1'b1;
        tick();
        check("set_wins", 32'(overflow), 32'h1);
        enable = 1'b0;
        tick();
        overflow_clr = 1'b0;
        check("clr2_ovf", 32'(overflow), 32'h0);

        // Full with simultaneous push and pop
        enable    = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample_in = 12'(12'h200 + i);
            tick();
            check("stream_level", 32'(level), 32'd8);
            check("stream_ovf", 32'(overflow), 32'h0);
        end
        enable = 1'b0;
        repeat (10) tick();
        check("drain_level", 32'(level), 32'd0);

        // decim=3 over 12 enabled cycles
        decim = 8'd3;
        enable = 1'b1;
        track  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample_in = 12'(12'h300 + i);
            tick();
        end
        enable = 1'b0;
        tick();
        track = 1'b0;
        check("dec3_count", 32'(rises.size()), 32'd3);
        if (rises.size() == 3) begin
            check("dec3_gap1", 32'(rises[1] - rises[0]), 32'd4);
            check("dec3_gap2", 32'(rises[2] - rises[1]), 32'd4);
        end

        // decim lowered below a running count wraps through 255
        decim  = 8'd10;
        enable = 1'b1;
        repeat (6) tick();
        decim = 8'd2;
        for (int i = 0; i < 240; i++) begin
            sample_in = 12'(i);
            tick();
        end
        check("wrap_nocap", 32'(out_valid), 32'h0);
        repeat (20) tick();
        enable = 1'b0;
        repeat (3) tick();

        // decim=255
        out_ready = 1'b0;
        decim     = 8'd255;
        enable    = 1'b1;
        sample_in = 12'habc;
        repeat (255) tick();
        check("d255_none", 32'(level), 32'd0);
        tick();
        check("d255_one", 32'(level), 32'd1);
        enable = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();

        // Reset mid-operation with a capture in the same cycle
        out_ready = 1'b0;
        decim     = 8'd0;
        enable    = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sample_in = 12'(12'h400 + i);
            tick();
        end
        enable    = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("pre_rst_level", 32'(level), 32'd5);
        out_ready = 1'b0;
        enable    = 1'b1;
        reset     = 1'b1;
        tick();
        reset  = 1'b0;
        enable = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'h0);

`ifdef SLOW_SAMPLE_PEAK_EN
        enable = 1'b1;
        sample_in = 12'h100;
        tick();
        sample_in = 12'hfff;
        tick();
        sample_in = 12'h010;
        tick();
        enable = 1'b0;
        tick();
        check("peak_max", 32'(peak), 32'hfff);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        check("peak_clr", 32'(peak), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            enable       = ($urandom_range(0, 9) < 8);
            decim        = 8'($urandom_range(0, 3));
            out_ready    = ($urandom_range(0, 2) == 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            reset        = ($urandom_range(0, 99) == 0);
            sample_in    = 12'($urandom);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
